// File: rtl/lamp_pkg.sv
// lamp_pkg: shared definitions for the room lighting ramp controller.
//   - one-hot time code constants
//   - controller state enum
//   - count -> thermometer vector helper (sized for the largest legal bank)
package lamp_pkg;

  // Widest lamp bank the 4-bit count can address.
  localparam int LAMP_MAXW = 15;

  localparam logic [3:0] TC_OFF0 = 4'b0000;
  localparam logic [3:0] TC_OFF1 = 4'b0001;
  localparam logic [3:0] TC_OFF2 = 4'b0010;
  localparam logic [3:0] TC_ROOM = 4'b0100;
  localparam logic [3:0] TC_USER = 4'b1000;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } lamp_state_e;

  // Bit i set iff i < n. 16-bit intermediate so n=15 yields 0x7FFF cleanly.
  function automatic logic [LAMP_MAXW-1:0] therm(input logic [3:0] n);
    logic [15:0] t;
    t = (16'd1 << n) - 16'd1;
    return t[LAMP_MAXW-1:0];
  endfunction

endpackage

// File: rtl/lamp_target_decode.sv
// lamp_target_decode: combinational time-code -> target lamp count.
// Ports:
//   tcode      in  4  one-hot time code
//   ulight     in  4  user-requested lamp count
//   length     in  4  square-room length (target = length/4)
//   cur_target in  4  currently latched target, returned for unknown codes
//   target     out 4  decoded target, clamped to NLAMP
module lamp_target_decode
  import lamp_pkg::*;
#(
  parameter int NLAMP = 15
) (
  input  logic [3:0] tcode,
  input  logic [3:0] ulight,
  input  logic [3:0] length,
  input  logic [3:0] cur_target,
  output logic [3:0] target
);

  localparam logic [3:0] NL4 = 4'(NLAMP);

  logic [3:0] room_cnt;
  logic       unused_len;

  // Room mode uses length/4; the low two bits never matter.
  assign room_cnt   = {2'b00, length[3:2]};
  assign unused_len = ^length[1:0];

  always_comb begin
    target = cur_target;
    case (tcode)
      TC_OFF0, TC_OFF1, TC_OFF2: target = 4'd0;
      TC_ROOM: target = (room_cnt > NL4) ? NL4 : room_cnt;
      TC_USER: target = (ulight > NL4) ? NL4 : ulight;
      default: target = cur_target;   // unknown code: hold target
    endcase
  end

endmodule

// File: rtl/lamp_ramp_ctrl.sv
// lamp_ramp_ctrl: soft start/stop sequencer for the room lighting bank.
// On update the decoded target is latched and the lit count walks toward it
// one lamp every STEP_CYCLES clocks, limiting inrush current.
// Ports:
//   clk        in   1      system clock, rising edge
//   rst        in   1      synchronous active-high reset
//   tcode      in   4      one-hot time code
//   ulight     in   4      user-requested lamp count
//   length     in   4      square-room length
//   update     in   1      single-cycle recompute/latch request
//   kill       in   1      emergency all-off (below rst only)
//   lamp_en    out  NLAMP  thermometer enable, bit i = (i < lit_count)
//   lit_count  out  4      lamps currently lit
//   busy       out  1      high while ramping
//   done       out  1      one-cycle pulse when a ramp lands on target
module lamp_ramp_ctrl
  import lamp_pkg::*;
#(
  parameter int NLAMP       = 15,
  parameter int STEP_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       tcode,
  input  logic [3:0]       ulight,
  input  logic [3:0]       length,
  input  logic             update,
  input  logic             kill,
  output logic [NLAMP-1:0] lamp_en,
  output logic [3:0]       lit_count,
  output logic             busy,
  output logic             done
);

  localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(STEP_CYCLES - 1);

  lamp_state_e      state;
  logic [TW-1:0]    timer;
  logic [3:0]       target_q;
  logic [3:0]       dec_target;
  logic [3:0]       tgt_eff;
  logic [3:0]       cnt_inc, cnt_dec;
  logic [NLAMP-1:0] en_inc, en_dec;
  logic [LAMP_MAXW-1:0] therm_inc, therm_dec;

  lamp_target_decode #(.NLAMP(NLAMP)) u_dec (
    .tcode      (tcode),
    .ulight     (ulight),
    .length     (length),
    .cur_target (target_q),
    .target     (dec_target)
  );

  // A mid-ramp update retargets on the same edge; unknown codes decode to
  // target_q so the ramp carries on untouched.
  assign tgt_eff = update ? dec_target : target_q;

  // Neighbouring counts and their enable vectors, so lamp_en and lit_count
  // are always loaded together. cnt_dec is only used when lit_count > target.
  always_comb begin
    cnt_inc   = lit_count + 4'd1;
    cnt_dec   = lit_count - 4'd1;
    therm_inc = therm(cnt_inc);
    therm_dec = therm(cnt_dec);
    en_inc    = therm_inc[NLAMP-1:0];
    en_dec    = therm_dec[NLAMP-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      target_q  <= 4'd0;
      lit_count <= 4'd0;
      lamp_en   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (kill) begin
      // Timer is left as-is; every ramp start reloads it anyway.
      state     <= IDLE;
      target_q  <= 4'd0;
      lit_count <= 4'd0;
      lamp_en   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (update) begin
            target_q <= dec_target;
            if (dec_target != lit_count) begin
              state <= RAMP;
              busy  <= 1'b1;
              timer <= RELOAD;
            end
          end
        end
        RAMP: begin
          if (update) target_q <= dec_target;
          if (tgt_eff == lit_count) begin
            // Retargeted onto the current count: land immediately.
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (timer != '0) begin
            timer <= timer - 1'b1;
          end else begin
            timer <= RELOAD;
            if (tgt_eff > lit_count) begin
              lit_count <= cnt_inc;
              lamp_en   <= en_inc;
              if (cnt_inc == tgt_eff) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              lit_count <= cnt_dec;
              lamp_en   <= en_dec;
              if (cnt_dec == tgt_eff) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
